// File: rtl/fibo_result_display_pkg.sv
// fibo_result_display_pkg: shared FSM encoding, segment constants and parameter helpers.
package fibo_result_display_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; nibbles 10-15 never occur after double-dabble, so they blank.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/fibo_result_display_if.sv
// fibo_result_display_if: calculator result input and board display outputs.
interface fibo_result_display_if #(
    parameter int size   = 4,
    parameter int DIGITS = 2
);
    logic              DONE;
    logic [size-1:0]   DATA;
    logic              BUSY;
    logic              VALID;
    logic [6:0]        SEG;
    logic [DIGITS-1:0] AN;

    modport master (output DONE, DATA, input BUSY, VALID, SEG, AN);
    modport slave  (input DONE, DATA, output BUSY, VALID, SEG, AN);
endinterface

// File: rtl/fibo_seg7_decode.sv
// fibo_seg7_decode: BCD nibble to active-low 7-segment pattern.
module fibo_seg7_decode
    import fibo_result_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nib];
endmodule

// File: rtl/fibo_result_display.sv
// fibo_result_display: captures calculator results on DONE rise, converts to BCD by
// double-dabble and drives a scanned active-low 7-segment display.
module fibo_result_display
    import fibo_result_display_pkg::*;
#(
    parameter int size        = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 16
) (
    input logic CLK,
    input logic RST,
    fibo_result_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(size + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    if (pow10(DIGITS) <= (64'd1 << size) || REFRESH_DIV < 2) begin : g_bad_param
        $fatal(1, "fibo_result_display: DIGITS too small for size, or REFRESH_DIV < 2");
    end

    state_t        state, state_nx;
    logic          done_q;
    logic [size-1:0] bin_sh, bin_nx;
    logic [BW-1:0] bcd_sh, bcd_adj, bcd_nx, digits;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rc;
    logic [IW-1:0] idx;
    logic [6:0]    seg_dec;
    logic          start, last;

    assign start = bus.DONE & ~done_q;
    assign last  = cnt == CW'(1);

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] >= 4'd5 ? bcd_sh[4*i +: 4] + 4'd3 : bcd_sh[4*i +: 4];
    end
    assign {bcd_nx, bin_nx} = {bcd_adj[BW-2:0], bin_sh, 1'b0};

    always_comb begin
        state_nx = state;
        state_nx = (state != CONVERT && start) ? CONVERT :
                   (state == CONVERT && last)  ? SHOW    : state;
    end

    fibo_seg7_decode u_dec (.nib(digits[{idx, 2'b00} +: 4]), .seg(seg_dec));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            bin_sh    <= '0;
            bcd_sh    <= '0;
            cnt       <= '0;
            digits    <= '0;
            rc        <= '0;
            idx       <= '0;
            bus.BUSY  <= 1'b0;
            bus.VALID <= 1'b0;
            bus.SEG   <= SEG_BLANK;
            bus.AN    <= '1;
        end else begin
            done_q   <= bus.DONE;
            state    <= state_nx;
            bus.BUSY <= state_nx == CONVERT;
            if (state != CONVERT && start) begin
                bin_sh <= bus.DATA;
                bcd_sh <= '0;
                cnt    <= CW'(size);
            end else if (state == CONVERT) begin
                bin_sh <= bin_nx;
                bcd_sh <= bcd_nx;
                cnt    <= cnt - 1'b1;
            end
            // Display digits only move when a conversion completes; old value stays up meanwhile.
            if (state == CONVERT && last) begin
                digits    <= bcd_nx;
                bus.VALID <= 1'b1;
            end
            rc <= rc == RW'(REFRESH_DIV - 1) ? '0 : rc + 1'b1;
            if (rc == RW'(REFRESH_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            bus.AN  <= ~(DIGITS'(1) << idx);
            bus.SEG <= bus.VALID ? seg_dec : SEG_BLANK;
        end
    end
endmodule
